// File: rtl/sprite_slot_pkg.sv
// Shared definitions for the sprite slot loader: command opcodes, slot
// register map and control-register bit positions.
package sprite_slot_pkg;

    typedef enum logic [1:0] {
        OP_LOAD       = 2'd0,
        OP_SET_POS    = 2'd1,
        OP_SET_SEL    = 2'd2,
        OP_SET_BYPASS = 2'd3
    } op_e;

    // addr[13] selects the register file instead of sprite RAM
    localparam int REG_SEL_BIT = 13;

    localparam logic [1:0] REG_BYPASS = 2'd0;
    localparam logic [1:0] REG_X0     = 2'd1;
    localparam logic [1:0] REG_Y0     = 2'd2;
    localparam logic [1:0] REG_SEL    = 2'd3;

    localparam int SEL_BIT    = 1;
    localparam int BYPASS_BIT = 0;

    // Slot address of a control register
    function automatic logic [13:0] reg_addr(input logic [1:0] off);
        logic [13:0] a;
        a = {12'd0, off};
        a[REG_SEL_BIT] = 1'b1;
        return a;
    endfunction

endpackage

// File: rtl/sprite_slot_loader.sv
// Slot-bus initiator: streams a sprite bitmap from a synchronous ROM into
// sprite RAM and writes the sprite control registers on command.
import sprite_slot_pkg::*;

module sprite_slot_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int PIX_W      = 3,
    parameter int SRC_AW     = 13,
    parameter int GATE_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [SRC_AW-1:0]     cmd_src_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [10:0]           cmd_x0,
    input  logic [10:0]           cmd_y0,
    input  logic                  cmd_flag,
    input  logic                  vblank,
    output logic [SRC_AW-1:0]     rom_addr,
    input  logic [PIX_W-1:0]      rom_data,
    output logic                  cs,
    output logic                  write,
    output logic [13:0]           addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_RUN   = 3'd1,
        LD_DRAIN = 3'd2,
        POS_WAIT = 3'd3,
        POS_X    = 3'd4,
        POS_Y    = 3'd5,
        REG_WR   = 3'd6,
        FIN      = 3'd7
    } state_e;

    // Largest legal bitmap: a full sprite RAM
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                 state_r;
    logic                   rd_v_r;      // a ROM read is presented this cycle
    logic [ADDR_WIDTH:0]    cnt_r;       // index of the pixel being read
    logic [ADDR_WIDTH:0]    len_r;
    logic [10:0]            x0_r;
    logic [10:0]            y0_r;
    logic                   p1_v_r;      // ROM data for pixel p1_idx_r is on rom_data
    logic [ADDR_WIDTH-1:0]  p1_idx_r;
    logic [ADDR_WIDTH:0]    cnt_next_s;
    logic                   len_bad_s;
    logic                   gate_s;

    assign cnt_next_s = cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign len_bad_s  = (cmd_len == {(ADDR_WIDTH+1){1'b0}}) || (cmd_len > MAX_LEN);
    assign gate_s     = (GATE_BLANK != 0) && !vblank;

    // Align the RAM index with the ROM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_v_r   <= 1'b0;
            p1_idx_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            p1_v_r   <= rd_v_r;
            p1_idx_r <= cnt_r[ADDR_WIDTH-1:0];
        end
    end

    // Command FSM with registered slot-bus, ROM address and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cs        <= 1'b0;
            write     <= 1'b0;
            addr      <= 14'd0;
            wr_data   <= 32'd0;
            rom_addr  <= {SRC_AW{1'b0}};
            rd_v_r    <= 1'b0;
            cnt_r     <= {(ADDR_WIDTH+1){1'b0}};
            len_r     <= {(ADDR_WIDTH+1){1'b0}};
            x0_r      <= 11'd0;
            y0_r      <= 11'd0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below
            done    <= 1'b0;
            err     <= 1'b0;
            cs      <= 1'b0;
            write   <= 1'b0;
            addr    <= 14'd0;
            wr_data <= 32'd0;

            // Pixel writes trail the reads by two cycles during a load
            if ((state_r == LD_RUN || state_r == LD_DRAIN) && p1_v_r) begin
                cs      <= 1'b1;
                write   <= 1'b1;
                addr    <= 14'(p1_idx_r);
                wr_data <= 32'(rom_data);
            end

            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (op_e'(cmd_op))
                            OP_LOAD: begin
                                if (len_bad_s) begin
                                    err     <= 1'b1;
                                    state_r <= FIN;
                                end else begin
                                    rom_addr <= cmd_src_base;
                                    cnt_r    <= {(ADDR_WIDTH+1){1'b0}};
                                    len_r    <= cmd_len;
                                    rd_v_r   <= 1'b1;
                                    state_r  <= LD_RUN;
                                end
                            end
                            OP_SET_POS: begin
                                x0_r <= cmd_x0;
                                y0_r <= cmd_y0;
                                if (gate_s) begin
                                    state_r <= POS_WAIT;
                                end else begin
                                    cs      <= 1'b1;
                                    write   <= 1'b1;
                                    addr    <= reg_addr(REG_X0);
                                    wr_data <= 32'(cmd_x0);
                                    state_r <= POS_X;
                                end
                            end
                            OP_SET_SEL: begin
                                cs      <= 1'b1;
                                write   <= 1'b1;
                                addr    <= reg_addr(REG_SEL);
                                wr_data <= 32'(cmd_flag) << SEL_BIT;
                                state_r <= REG_WR;
                            end
                            OP_SET_BYPASS: begin
                                cs      <= 1'b1;
                                write   <= 1'b1;
                                addr    <= reg_addr(REG_BYPASS);
                                wr_data <= 32'(cmd_flag) << BYPASS_BIT;
                                state_r <= REG_WR;
                            end
                            default: begin
                                state_r <= FIN;
                            end
                        endcase
                    end
                end
                LD_RUN: begin
                    if (cnt_next_s == len_r) begin
                        rd_v_r  <= 1'b0;
                        state_r <= LD_DRAIN;
                    end else begin
                        cnt_r    <= cnt_next_s;
                        rom_addr <= rom_addr + SRC_AW'(1);
                    end
                end
                LD_DRAIN: begin
                    if (!p1_v_r) begin
                        done    <= 1'b1;
                        state_r <= FIN;
                    end
                end
                POS_WAIT: begin
                    if (vblank) begin
                        cs      <= 1'b1;
                        write   <= 1'b1;
                        addr    <= reg_addr(REG_X0);
                        wr_data <= 32'(x0_r);
                        state_r <= POS_X;
                    end
                end
                POS_X: begin
                    // y0 follows x0 unconditionally so the pair is never split
                    cs      <= 1'b1;
                    write   <= 1'b1;
                    addr    <= reg_addr(REG_Y0);
                    wr_data <= 32'(y0_r);
                    state_r <= POS_Y;
                end
                POS_Y, REG_WR: begin
                    done    <= 1'b1;
                    state_r <= FIN;
                end
                FIN: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    rd_v_r    <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_slot_loader.sv
// Directed self-checking bench for sprite_slot_loader with a synchronous ROM model.
module tb_sprite_slot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [12:0] cmd_src_base = 13'd0;
    logic [11:0] cmd_len = 12'd0;
    logic [10:0] cmd_x0 = 11'd0;
    logic [10:0] cmd_y0 = 11'd0;
    logic        cmd_flag = 1'b0;
    logic        vblank = 1'b0;
    logic [12:0] rom_addr;
    logic [2:0]  rom_data;
    logic        cs, write, busy, done, err;
    logic [13:0] addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_bad = 0;
    bit mon_en = 1'b0;
    logic ready_prev = 1'b1;

    logic [2:0] rom [0:8191];
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int done_q[$];
    int err_q[$];
    int ready_q[$];

    sprite_slot_loader #(.ADDR_WIDTH(11), .PIX_W(3), .SRC_AW(13), .GATE_BLANK(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src_base(cmd_src_base), .cmd_len(cmd_len),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_flag(cmd_flag), .vblank(vblank),
        .rom_addr(rom_addr), .rom_data(rom_data), .cs(cs), .write(write),
        .addr(addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter: value seen at a negedge names the current cycle
    always @(posedge clk) cyc++;

    // Synchronous-read source ROM
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Slot-bus and status monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (cs === 1'b1) begin
                wq_addr.push_back(int'(addr));
                wq_data.push_back(int'(wr_data));
                wq_cyc.push_back(cyc);
            end
            if (done === 1'b1) done_q.push_back(cyc);
            if (err === 1'b1) err_q.push_back(cyc);
            if (cmd_ready === 1'b1 && ready_prev !== 1'b1) ready_q.push_back(cyc);
            if (cs !== write || (cs !== 1'b1 && (addr !== 14'd0 || wr_data !== 32'd0))) strobe_bad++;
            ready_prev = cmd_ready;
        end
    end

    task automatic clear_logs();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        done_q.delete(); err_q.delete(); ready_q.delete();
    endtask

    // Offer one command at a negedge; returns the acceptance cycle
    task automatic send(input logic [1:0] op, input logic [12:0] base, input logic [11:0] len,
                        input logic [10:0] x, input logic [10:0] y, input logic flag, output int a);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_op = op; cmd_src_base = base; cmd_len = len;
        cmd_x0 = x; cmd_y0 = y; cmd_flag = flag; cmd_valid = 1'b1;
        a = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x0 = 11'h555; cmd_y0 = 11'h2AA; cmd_len = 12'd0;
    endtask

    // Check a completed LOAD against the ROM model
    task automatic check_load(input string nm, input int a, input int base, input int n);
        int bad = 0;
        int first = -1;
        checks++;
        if (wq_addr.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d writes required %0d", nm, wq_addr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (wq_addr[i] != i || wq_data[i] != int'(rom[(base + i) % 8192]) || wq_cyc[i] != a + 3 + i) begin
                    if (first < 0) first = i;
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_writes: %0d bad, first idx %0d addr=%h data=%0d cyc=%0d required addr=%h data=%0d cyc=%0d",
                         nm, bad, first, wq_addr[first], wq_data[first], wq_cyc[first],
                         first, rom[(base + first) % 8192], a + 3 + first);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != a + 3 + n) begin
            errors++;
            $display("FAIL %s_done: count=%0d first=%0d required one at %0d", nm, done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, a + 3 + n);
        end
        checks++;
        if (ready_q.size() != 1 || ready_q[0] != a + 4 + n) begin
            errors++;
            $display("FAIL %s_ready: count=%0d first=%0d required one at %0d", nm, ready_q.size(),
                     (ready_q.size() > 0) ? ready_q[0] : -1, a + 4 + n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b1 || cs !== 1'b0 || write !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || err !== 1'b0 || addr !== 14'd0 || wr_data !== 32'd0 || rom_addr !== 13'd0) begin
                errors++;
                $display("FAIL reset_idle: cyc %0d ready=%b cs=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h rom=%h required 1,0,0,0,0,0,0,0,0",
                         i, cmd_ready, cs, write, busy, done, err, addr, wr_data, rom_addr);
            end
        end
    endtask

    task automatic test_load_small();
        int a;
        clear_logs();
        send(2'd0, 13'h0100, 12'd4, 11'd0, 11'd0, 1'b0, a);
        repeat (12) @(negedge clk);
        check_load("load4", a, 'h100, 4);
        checks++;
        if (wq_data.size() == 4 && (wq_data[0] != 1 || wq_data[1] != 2 || wq_data[2] != 3 || wq_data[3] != 4)) begin
            errors++;
            $display("FAIL load4_pixels: got %0d %0d %0d %0d required 1 2 3 4", wq_data[0], wq_data[1], wq_data[2], wq_data[3]);
        end
        checks++;
        if (rom_addr !== 13'h0103) begin
            errors++;
            $display("FAIL load4_rom_hold: rom_addr=%h required 0103", rom_addr);
        end
    endtask

    task automatic test_load_wrap();
        int a;
        clear_logs();
        send(2'd0, 13'h1FFE, 12'd2048, 11'd0, 11'd0, 1'b0, a);
        repeat (2060) @(negedge clk);
        check_load("load_wrap", a, 'h1FFE, 2048);
        checks++;
        if (wq_addr.size() == 0 || wq_addr[wq_addr.size() - 1] != 'h7FF) begin
            errors++;
            $display("FAIL load_wrap_last: last addr=%h required 07ff",
                     (wq_addr.size() > 0) ? wq_addr[wq_addr.size() - 1] : -1);
        end
        checks++;
        if (rom_addr !== 13'h07FD) begin
            errors++;
            $display("FAIL load_wrap_rom: rom_addr=%h required 07fd", rom_addr);
        end
    endtask

    task automatic test_bad_len(input logic [11:0] len);
        int a;
        clear_logs();
        send(2'd0, 13'h0010, len, 11'd0, 11'd0, 1'b0, a);
        repeat (6) @(negedge clk);
        checks++;
        if (err_q.size() != 1 || err_q[0] != a + 1) begin
            errors++;
            $display("FAIL bad_len_err: len=%0d count=%0d first=%0d required one at %0d", len, err_q.size(),
                     (err_q.size() > 0) ? err_q[0] : -1, a + 1);
        end
        checks++;
        if (wq_addr.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL bad_len_quiet: len=%0d writes=%0d dones=%0d required 0 0", len, wq_addr.size(), done_q.size());
        end
        checks++;
        if (ready_q.size() != 1 || ready_q[0] != a + 2) begin
            errors++;
            $display("FAIL bad_len_ready: len=%0d first=%0d required %0d", len,
                     (ready_q.size() > 0) ? ready_q[0] : -1, a + 2);
        end
    endtask

    task automatic test_reg_write(input string nm, input logic [1:0] op, input logic flag, input int exp_addr, input int exp_data);
        int a;
        clear_logs();
        vblank = 1'b0;
        send(op, 13'd0, 12'd0, 11'd0, 11'd0, flag, a);
        repeat (5) @(negedge clk);
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] != exp_addr || wq_data[0] != exp_data || wq_cyc[0] != a + 1) begin
            errors++;
            $display("FAIL %s_write: count=%0d addr=%h data=%h cyc=%0d required 1 %h %h %0d", nm, wq_addr.size(),
                     (wq_addr.size() > 0) ? wq_addr[0] : -1, (wq_data.size() > 0) ? wq_data[0] : -1,
                     (wq_cyc.size() > 0) ? wq_cyc[0] : -1, exp_addr, exp_data, a + 1);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != a + 2) begin
            errors++;
            $display("FAIL %s_done: first=%0d required %0d", nm, (done_q.size() > 0) ? done_q[0] : -1, a + 2);
        end
    endtask

    task automatic test_set_pos();
        int a;
        int v;
        clear_logs();
        vblank = 1'b0;
        send(2'd1, 13'd0, 12'd0, 11'd300, 11'd120, 1'b0, a);
        repeat (49) @(negedge clk);
        checks++;
        if (wq_addr.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pos_wait: writes=%0d busy=%b required 0 1", wq_addr.size(), busy);
        end
        vblank = 1'b1;
        v = cyc;
        @(negedge clk);
        vblank = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wq_addr.size() != 2) begin
            errors++;
            $display("FAIL pos_count: got %0d writes required 2", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] != 'h2001 || wq_data[0] != 300 || wq_cyc[0] != v + 1) begin
                errors++;
                $display("FAIL pos_x0: addr=%h data=%0d cyc=%0d required 2001 300 %0d", wq_addr[0], wq_data[0], wq_cyc[0], v + 1);
            end
            checks++;
            if (wq_addr[1] != 'h2002 || wq_data[1] != 120 || wq_cyc[1] != v + 2) begin
                errors++;
                $display("FAIL pos_y0: addr=%h data=%0d cyc=%0d required 2002 120 %0d", wq_addr[1], wq_data[1], wq_cyc[1], v + 2);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != v + 3) begin
            errors++;
            $display("FAIL pos_done: first=%0d required %0d", (done_q.size() > 0) ? done_q[0] : -1, v + 3);
        end
    endtask

    task automatic test_abort();
        int a;
        int r;
        int n = 0;
        int late = 0;
        clear_logs();
        send(2'd0, 13'h0000, 12'd64, 11'd0, 11'd0, 1'b0, a);
        while (wq_addr.size() < 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wq_addr.size() < 10) begin
            errors++;
            $display("FAIL abort_start: writes=%0d required 10", wq_addr.size());
        end
        reset = 1'b1;
        r = cyc;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (cs !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset: cs=%b busy=%b ready=%b required 0 0 1", cs, busy, cmd_ready);
        end
        repeat (80) @(negedge clk);
        foreach (wq_cyc[i]) if (wq_cyc[i] > r) late++;
        checks++;
        if (late != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet: late writes=%0d dones=%0d required 0 0", late, done_q.size());
        end
        clear_logs();
        send(2'd0, 13'h0020, 12'd8, 11'd0, 11'd0, 1'b0, a);
        repeat (16) @(negedge clk);
        check_load("after_abort", a, 'h20, 8);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 3'((i * 5) ^ (i >> 3));
        rom[256] = 3'd1; rom[257] = 3'd2; rom[258] = 3'd3; rom[259] = 3'd4;

        test_reset();
        test_load_small();
        test_load_wrap();
        test_bad_len(12'd0);
        test_bad_len(12'd2049);
        test_reg_write("bypass", 2'd3, 1'b1, 'h2000, 1);
        test_reg_write("sel", 2'd2, 1'b1, 'h2003, 2);
        test_set_pos();
        test_abort();

        checks++;
        if (strobe_bad != 0) begin
            errors++;
            $display("FAIL bus_idle_rules: %0d cycles with cs/write mismatch or nonzero idle bus, required 0", strobe_bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_slot_loader.md
Name: sprite_slot_loader

Overview:
- Bus initiator that drives the video-slot write interface (cs/write/addr/wr_data) of a sprite core.
- Streams a sprite bitmap from a synchronous-read source ROM into the sprite RAM, one pixel per cycle.
- Writes the sprite control registers: position, select and bypass.
- Position updates can be held until vertical blanking to avoid tearing. Commands come from the game-logic/MicroBlaze glue through a valid/ready port.

Parameters:
- ADDR_WIDTH, 11, sprite RAM address width; a bitmap holds at most 2**ADDR_WIDTH pixels.
- PIX_W, 3, pixel width in bits carried on wr_data[PIX_W-1:0].
- SRC_AW, 13, source ROM address width.
- GATE_BLANK, 1, 1 = position writes wait for vblank high; 0 = issue immediately.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a clk edge with cmd_valid&cmd_ready.
- cmd_op  in  2  0=LOAD bitmap, 1=SET_POS, 2=SET_SEL, 3=SET_BYPASS.
- cmd_src_base  in  SRC_AW  ROM start address (LOAD).
- cmd_len  in  ADDR_WIDTH+1  pixel count (LOAD).
- cmd_x0, cmd_y0  in  11 each  sprite origin (SET_POS).
- cmd_flag  in  1  value for SET_SEL / SET_BYPASS.
- vblank  in  1  vertical blanking indicator, synchronous to clk.
- rom_addr  out  SRC_AW  source ROM address; data is returned one cycle later.
- rom_data  in  PIX_W  source ROM read data.
- cs, write  out  1 each  slot strobes; always asserted together.
- addr  out  14  slot address; bit 13: 0 = RAM, 1 = register.
- wr_data  out  32  slot write data.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when a LOAD command is rejected.

Behaviour:
- Reset values: cmd_ready=1 after reset. All other outputs are 0: busy, done, err, cs, write, addr, wr_data, rom_addr.
- Reset mid-command: aborts on that edge, returns to IDLE, no done pulse. No slot write appears in the cycle after reset.
- Output registration: all outputs are registered. When cs=0, addr and wr_data are driven to 0. Unused wr_data bits are always 0.
- States: IDLE, LD_RUN, LD_DRAIN, POS_WAIT, POS_X, POS_Y, REG_WR, FIN.
- Timing reference: A = the cycle in which a command is accepted.
- LOAD, rejected: cmd_len==0 or cmd_len>2**ADDR_WIDTH. Accepted, err=1 in cycle A+1, no slot or ROM activity, back to IDLE with cmd_ready=1 in A+2. No done pulse.
- LOAD, valid length N:
  - Pixel i is read with rom_addr = (cmd_src_base+i) mod 2**SRC_AW, driven in cycle A+1+i.
  - Its slot write appears in cycle A+3+i with cs=write=1, addr={1'b0, zeros, i[ADDR_WIDTH-1:0]} and wr_data[PIX_W-1:0]=rom_data.
  - Writes occupy consecutive cycles with no gaps. The last write is in A+2+N.
  - done=1 in A+3+N; cmd_ready=1 in A+4+N.
  - rom_addr holds its last value after the final read.
- SET_POS:
  - If GATE_BLANK=1 and vblank is sampled low, wait in POS_WAIT.
  - On the first edge that samples vblank=1 (or immediately if not gated), write x0 next: addr=14'h2001, wr_data[10:0]=cmd_x0.
  - Then write y0 on the following cycle: addr=14'h2002, wr_data[10:0]=cmd_y0. The y0 write is issued even if vblank has dropped.
  - done follows the y0 write by one cycle.
  - x0/y0 are captured at acceptance; later changes on cmd_* are ignored.
- SET_SEL: one write, addr=14'h2003, wr_data[1]=cmd_flag, wr_data[0]=0.
- SET_BYPASS: one write, addr=14'h2000, wr_data[0]=cmd_flag.
- Register-write timing: SET_SEL/SET_BYPASS write in A+1, done in A+2. These two are never gated by vblank.
- Ordering: commands are strictly serialised; there is no overlap between commands. cmd_valid while busy has no effect.

Decomposition:
- Package sprite_slot_pkg holds:
  - op enum (OP_LOAD, OP_SET_POS, OP_SET_SEL, OP_SET_BYPASS);
  - REG_SEL_BIT=13;
  - register offsets BYPASS=0, X0=1, Y0=2, SEL=3;
  - wr_data bit positions SEL_BIT=1, BYPASS_BIT=0.
- Single module, one FSM plus a pixel counter and a 2-stage address/valid pipeline. No sub-module.

Test Plan:
- Reset then idle -> cmd_ready=1; cs, write, busy, done, err all 0 for 10 cycles.
- LOAD base=0x0100, len=4, ROM[0x100..0x103]=1,2,3,4 -> writes at A+3..A+6 to addr 0x0000..0x0003 with data 1,2,3,4; done at A+7.
- LOAD base=0x1FFE, len=2048 -> rom_addr wraps 0x1FFF->0x0000; 2048 back-to-back writes; last addr=0x07FF.
- LOAD len=0 and len=2049 -> err pulse at A+1, no cs; then SET_BYPASS flag=1 -> addr=0x2000, wr_data=1, done at A+2.
- SET_POS x0=300, y0=120, vblank low for 50 cycles then high -> no cs while low; x0 write (0x2001, 300) then y0 write (0x2002, 120) on consecutive cycles even if vblank drops after one cycle.
- Reset asserted at 10th pixel of a len=64 LOAD -> no further cs after reset, no done; next LOAD completes normally.
